alu_shift_seq: RTL
==================

Name: alu_shift_seq

Overview:
Multi-cycle shift unit. It is the area-reduced counterpart of the single-cycle combinational shifter.
- Accepts one shift operation per request through a valid/ready handshake.
- Shifts iteratively, at most SHIFT_STEP bit positions per cycle.
- Returns the result through a second valid/ready handshake.
- Sits in the execute stage, fed by the instruction decoder and register file, drained by writeback.
- For any accepted operation, the final result is bit-identical to the combinational shifter.

Parameters:
DATA_WIDTH, simple_processor_pkg::DATA_WIDTH (32), operand and result width.
SHIFT_STEP, 4, maximum bit positions shifted per cycle; power of two, 1..DATA_WIDTH.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
arst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  request valid.
ready_o  output  1  unit can accept a request.
func_i  input  func_t  operation: SLL, SLLI, SLR or SLRI.
rs1_data_i  input  DATA_WIDTH  value to shift.
rs2_data_i  input  DATA_WIDTH  shift amount for SLL and SLR.
imm_i  input  6  immediate shift amount for SLLI and SLRI.
flush_i  input  1  synchronous abort of the in-flight operation.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts the result.
result_o  output  DATA_WIDTH  working/result register.

Behaviour:
- Reset is asynchronous and active-low. While arst_ni = 0:
  - state = IDLE;
  - ready_o = 1, valid_o = 0;
  - result_o = 0, remaining count = 0.
  Reset asserted mid-operation discards that operation immediately.
- Operation decode is sampled only at acceptance (valid_i && ready_o):
  - SLL: left shift, amount = rs2_data_i.
  - SLLI: left shift, amount = sign-extended imm_i (DATA_WIDTH bits).
  - SLR: logical right shift, amount = rs2_data_i.
  - SLRI: logical right shift, amount = sign-extended imm_i.
  - Any other func_i value is treated as SLR.
- Amount rule: the full DATA_WIDTH-bit amount is compared.
  - Amount >= DATA_WIDTH saturates to DATA_WIDTH, giving result 0.
  - A negative immediate (e.g. 6'h3F = 0xFFFFFFFF) therefore gives 0.
  - Remaining-count register width is $clog2(DATA_WIDTH)+1.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - ready_o = 1, valid_o = 0.
    - On acceptance, load result_o <= rs1_data_i, latch direction, and load remaining <= saturated amount.
    - Next state is DONE if the amount is 0, otherwise SHIFT.
  - SHIFT:
    - ready_o = 0, valid_o = 0.
    - Each cycle, shift result_o by n = min(SHIFT_STEP, remaining) in the latched direction, zero-filling.
    - remaining -= n.
    - When remaining reaches 0 on this edge, go to DONE.
  - DONE:
    - ready_o = 0, valid_o = 1, result_o held stable.
    - On ready_i = 1, go to IDLE.
    - No new request is accepted in the same cycle; ready_o is only asserted in IDLE.
- Latency: with k = ceil(saturated_amount / SHIFT_STEP), valid_o rises k+1 cycles after the acceptance edge.
  - Amount 0 gives latency 1.
  - Worst case with defaults is 9 (amount 32, k = 8).
- Backpressure: in DONE, valid_o and result_o stay stable for any number of cycles until ready_i = 1.
- Flush:
  - flush_i = 1 in SHIFT or DONE sends the unit to IDLE on the next edge and clears remaining.
  - valid_o is low from that edge onward; result_o holds its last value.
  - flush_i has priority over ready_i and over a completing shift.
  - In IDLE, flush_i has priority over valid_i: no acceptance occurs.
- Inputs other than valid_i, ready_i and flush_i are ignored outside the acceptance cycle.

Test Plan:
1. Reset, then SLL with rs1 = 0x0000_0001, rs2 = 4, ready_i = 1 → valid_o is high 2 cycles after acceptance, result_o = 0x0000_0010, ready_o returns high the cycle after.
2. SLR with rs1 = 0xF000_0000, rs2 = 0 → valid_o after 1 cycle, result_o = 0xF000_0000.
3. SLRI with rs1 = 0xFFFF_FFFF, imm = 6'h3F → amount saturates to 32, valid_o after 9 cycles, result_o = 0. SLLI with imm = 6'd7 on 0x1 → 0x80 after 3 cycles.
4. SLL of 0x1 by rs2 = 31, ready_i held low 5 cycles after valid_o → valid_o and result_o = 0x8000_0000 stay stable; valid_i pulses during DONE are not accepted (ready_o = 0).
5. flush_i pulsed in cycle 2 of a 32-bit SLR → next cycle state is IDLE, valid_o = 0, ready_o = 1. A following SLL of 0x3 by 1 returns 0x6.
6. arst_ni asserted mid-SHIFT → outputs go to reset values immediately, without waiting for a clock edge. Random func, operand and amount sweep after release → every result matches the combinational reference model, and each latency equals k+1.

Source files
------------

// File: rtl/alu_shift_seq.sv
// Multi-cycle logical shifter: accepts one SLL/SLLI/SLR/SLRI request, shifts up to
// SHIFT_STEP positions per cycle and presents the result through a valid/ready handshake.
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_OR   = 4'd3,
    FN_XOR  = 4'd4,
    FN_SLL  = 4'd5,
    FN_SLLI = 4'd6,
    FN_SLR  = 4'd7,
    FN_SLRI = 4'd8
  } func_t;
endpackage

// state | meaning
// IDLE  | ready for a request, no result pending
// SHIFT | iterating, remaining_q positions still to shift
// DONE  | result_o valid, waiting for ready_i
module alu_shift_seq #(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int SHIFT_STEP = 4
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  simple_processor_pkg::func_t func_i,
  input  logic [DATA_WIDTH-1:0]       rs1_data_i,
  input  logic [DATA_WIDTH-1:0]       rs2_data_i,
  input  logic [5:0]                  imm_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_WIDTH-1:0]       result_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] WIDTH_AMT = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      WIDTH_CNT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      STEP_CNT  = CNT_W'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  left_q, left_d;

  logic                  is_imm;
  logic                  is_left;
  logic [DATA_WIDTH-1:0] amt_full;
  logic [CNT_W-1:0]      amt_sat;
  logic [CNT_W-1:0]      step_n;

  // Decode: anything that is not an explicit left shift behaves as SLR.
  always_comb begin
    is_imm   = (func_i == simple_processor_pkg::FN_SLLI) ||
               (func_i == simple_processor_pkg::FN_SLRI);
    is_left  = (func_i == simple_processor_pkg::FN_SLL) ||
               (func_i == simple_processor_pkg::FN_SLLI);
    amt_full = is_imm ? {{(DATA_WIDTH-6){imm_i[5]}}, imm_i} : rs2_data_i;
    amt_sat  = (amt_full >= WIDTH_AMT) ? WIDTH_CNT : amt_full[CNT_W-1:0];
    step_n   = (remaining_q < STEP_CNT) ? remaining_q : STEP_CNT;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    remaining_d = remaining_q;
    left_d      = left_q;
    ready_o     = 1'b0;
    valid_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !flush_i) begin
          result_d    = rs1_data_i;
          left_d      = is_left;
          remaining_d = amt_sat;
          state_d     = (amt_sat == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (flush_i) begin
          remaining_d = '0;
          state_d     = S_IDLE;
        end else begin
          result_d    = left_q ? (result_q << step_n) : (result_q >> step_n);
          remaining_d = remaining_q - step_n;
          if (remaining_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (flush_i) begin
          remaining_d = '0;
          state_d     = S_IDLE;
        end else if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        remaining_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      remaining_q <= '0;
      left_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      remaining_q <= remaining_d;
      left_q      <= left_d;
    end
  end

  assign result_o = result_q;

endmodule
